// File: rtl/rr_lock_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter_pkg
// Purpose  : Shared types and constants for the round-robin lock arbiter.
//            Holds the arbiter state encoding used by the top-level FSM.
// Contents : STATE_W  - width of the state encoding
//            state_t  - IDLE (no holder) / LOCKED (grant held until done)
// Revision : 1.0 - initial release
// ============================================================================
package rr_lock_arbiter_pkg;

  localparam int STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage : rr_lock_arbiter_pkg
`default_nettype wire

// File: rtl/rr_lock_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter_if
// Purpose  : Request/grant bundle between the requesters and the arbiter.
// Signals  : req       [n-1:0] request vector, bit i = requester i
//            done              holder releases the resource this cycle
//            grant     [n-1:0] one-hot grant, zero when idle
//            grant_idx [m-1:0] binary index of current/last holder
//            busy              resource currently granted
// Modports : master - requester side (drives req/done)
//            slave  - arbiter side (drives grant/grant_idx/busy)
// Revision : 1.0 - initial release
// ============================================================================
interface rr_lock_arbiter_if #(
  parameter int m = 2,
  parameter int n = 1 << m
);

  logic [n-1:0] req;
  logic         done;
  logic [n-1:0] grant;
  logic [m-1:0] grant_idx;
  logic         busy;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output busy
  );

endinterface : rr_lock_arbiter_if
`default_nettype wire

// File: rtl/rr_lock_arbiter_decoder.sv
`default_nettype none
// ============================================================================
// Module   : DecoderVRTL
// Purpose  : Binary-to-one-hot decoder, m-bit index to 2**m select lines.
// Ports    : idx    [m-1:0]      input  binary index
//            onehot [(1<<m)-1:0] output exactly one bit set, bit idx
// Revision : 1.0 - initial release
// ============================================================================
module DecoderVRTL #(
  parameter int m = 2
) (
  input  wire logic [m-1:0]      idx,
  output      logic [(1<<m)-1:0] onehot
);

  for (genvar i = 0; i < (1 << m); i++) begin : g_dec
    localparam logic [m-1:0] c_idx = i;
    assign onehot[i] = (idx == c_idx);
  end

endmodule : DecoderVRTL
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter
// Purpose  : Round-robin arbiter with grant lock. A selected requester keeps
//            the grant until it pulses done; priority then moves past it.
//            At least one IDLE cycle separates consecutive grants.
// Ports    : clk    input  rising-edge clock
//            reset  input  asynchronous active-low reset
//            bus    slave  req/done in, grant/grant_idx/busy out
// Revision : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int m = 2,
  parameter int n = 1 << m
) (
  input wire logic         clk,
  input wire logic         reset,
  rr_lock_arbiter_if.slave bus
);

  state_t       r_state, w_state_nxt;
  logic [m-1:0] r_ptr, w_ptr_nxt;
  logic [m-1:0] r_idx, w_idx_nxt;
  logic [m-1:0] w_sel;
  logic [m-1:0] w_cand;
  logic         w_found;
  logic         w_busy;
  logic [n-1:0] w_onehot;

  // Circular first-one search starting at r_ptr. Candidate index wraps
  // naturally because it is m bits wide and n = 2**m.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_cand  = r_ptr;
    for (int k = 0; k < n; k++) begin
      w_cand = r_ptr + k[m-1:0];
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Next-state logic. req is only looked at in IDLE, so requests that
  // arrive alongside done wait for the bubble cycle that follows.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_idx_nxt   = w_sel;
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (bus.done) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_idx + {{(m-1){1'b0}}, 1'b1};
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  DecoderVRTL #(.m(m)) u_dec (
    .idx    (r_idx),
    .onehot (w_onehot)
  );

  // grant_idx keeps the last holder while idle, so the decoded vector
  // must be gated to stay zero outside LOCKED.
  assign w_busy        = (r_state == LOCKED);
  assign bus.busy      = w_busy;
  assign bus.grant_idx = r_idx;
  assign bus.grant     = w_onehot & {n{w_busy}};

endmodule : rr_lock_arbiter
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_lock_arbiter
// Purpose  : Directed self-checking bench for rr_lock_arbiter (m=2, n=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_lock_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  rr_lock_arbiter_if #(.m(2)) bus ();

  rr_lock_arbiter #(.m(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lock(input string tag, input int idx);
    chk({tag, "_idx"},   int'(bus.grant_idx), idx);
    chk({tag, "_grant"}, int'(bus.grant),     1 << idx);
    chk({tag, "_busy"},  int'(bus.busy),      1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, int'(bus.grant), 0);
    chk({tag, "_busy"},  int'(bus.busy),  0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 1'b0;

    // Reset held with all requesting
    tick();
    tick();
    chk_idle("reset");
    chk("reset_idx", int'(bus.grant_idx), 0);

    // Release; done held high so every LOCKED cycle releases
    reset    = 1'b1;
    bus.done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_lock($sformatf("rot%0d", k), k % 4);
      tick();
      chk_idle($sformatf("rot%0d_bubble", k));
    end
    // ptr is now 1

    // done in IDLE with no requests must not move ptr
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    tick();
    tick();
    tick();
    chk_idle("ign_idle");
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    tick();
    chk_lock("ign_grant", 1);
    bus.done = 1'b1;
    tick();
    chk_idle("ign_rel");
    bus.done = 1'b0;
    // ptr is now 2

    // Single requester, grant held after req drops
    bus.req = 4'b0100;
    tick();
    chk_lock("single", 2);
    bus.req = 4'b0000;
    tick();
    chk_lock("single_hold1", 2);
    tick();
    chk_lock("single_hold2", 2);
    bus.done = 1'b1;
    tick();
    chk_idle("single_rel");
    chk("single_rel_idx", int'(bus.grant_idx), 2);
    bus.done = 1'b0;
    bus.req  = 4'b1111;
    tick();
    chk_lock("single_next", 3);

    // Wrap: holder 3 releases with new requests arriving alongside done
    bus.done = 1'b1;
    bus.req  = 4'b1001;
    tick();
    chk_idle("wrap_rel");
    bus.done = 1'b0;
    tick();
    chk_lock("wrap_grant0", 0);
    bus.done = 1'b1;
    tick();
    chk_idle("wrap_rel0");
    bus.done = 1'b0;
    tick();
    chk_lock("wrap_grant3", 3);

    // Build a lock on requester 1 with ptr = 1
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0001;
    tick();
    chk_lock("pre0", 0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0010;
    tick();
    chk_lock("pre1", 1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk_idle("areset");
    chk("areset_idx", int'(bus.grant_idx), 0);
    #2;
    reset   = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk_lock("areset_ptr0", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_lock_arbiter
`default_nettype wire

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin arbiter with grant lock. It shares one resource between n requesters. Example: a shared datapath whose select lines are driven by the one-hot decoder.
- The arbiter picks one requester and holds the grant until the holder signals done. It then advances priority past that holder.
- The grant is presented two ways: as a binary index, and as a one-hot vector produced by the team's decoder.

Parameters:
- m, 2, width of the requester index (log2 of requester count).
- n, 1 << m, number of requesters. Always a power of two; not overridden independently of m.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset. 0 resets the block immediately, independent of clk.
- req  input  n  request vector; bit i = requester i wants the resource.
- done  input  1  current holder releases the resource this cycle. Meaningful only while busy=1.
- grant  output  n  one-hot grant, all zeros when idle.
- grant_idx  output  m  binary index of the current holder. Holds the last holder's value while idle.
- busy  output  1  resource currently granted.

Behaviour:
- State register: state in {IDLE, LOCKED}, plus ptr[m-1:0] (the highest-priority index) and grant_idx[m-1:0]. All are flops with asynchronous active-low reset.
- Reset values (while reset=0): state=IDLE, ptr=0, grant_idx=0, busy=0, grant=0. Asserting reset mid-operation drops grant and busy immediately (asynchronously).
- grant is combinational from registered state: grant = onehot(grant_idx) when busy=1, else all zeros. It never has more than one bit set.
- busy = (state == LOCKED).
- IDLE:
  - If req == 0: stay IDLE.
  - Else: select sel = the first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+n-1 modulo n (wrap-around).
  - Next edge: grant_idx <= sel, state <= LOCKED.
  - Latency from req sampled to grant visible is 1 cycle.
- LOCKED:
  - Grant is held. Changes on req, including the holder dropping its own req bit, do not change grant.
  - On an edge with done=1: state <= IDLE, ptr <= grant_idx + 1 (m-bit wrap, so n-1 goes to 0). grant_idx keeps its value.
  - grant and busy deassert the cycle after done.
- Mandatory bubble: at least one IDLE cycle between consecutive grants. Minimum grant period is 2 cycles (grant cycle plus done in the same cycle, then IDLE).
- done while IDLE is ignored; ptr does not change.
- Simultaneous events:
  - Requests arriving in the same cycle as done are not considered until the following IDLE cycle.
  - In IDLE, all bits of req are evaluated together. Priority is purely rotational from ptr, with no fixed bias.
- Fairness: with all n requesting continuously, grants cycle ptr, ptr+1, ... mod n. Every requester is served within n grant cycles.

Decomposition:
- Shared package holds the state enum typedef {IDLE, LOCKED}. The state-width constant is 1.
- One sub-module: DecoderVRTL (parameter m) converts grant_idx to one-hot. Its output is ANDed with busy.
- The rotating priority search (a circular first-one scan from ptr) stays inline as a combinational loop. It is not a separate module.

Test Plan (m=2, n=4):
- Reset: hold reset=0 with req=4'b1111 -> grant=0, busy=0, grant_idx=0. Release reset -> one cycle later grant=4'b0001, grant_idx=0.
- Single requester: req=4'b0100 from IDLE, ptr=0 -> next cycle grant=4'b0100, grant_idx=2, busy=1. Drop req while done=0 -> grant stays 4'b0100. Pulse done -> grant=0 next cycle, and ptr=3 is observed by the next arbitration.
- Rotation: req=4'b1111 held, done pulsed in every LOCKED cycle -> grant_idx sequence 0,1,2,3,0 with one idle cycle between each.
- Wrap: holder idx 3 releases, then req=4'b1001 -> grant_idx=0 (ptr wrapped to 0). Next grant after release -> 3.
- done ignored: done=1 in IDLE with req=0 -> ptr unchanged. A later req=4'b1111 is granted to the previous ptr value.
- Async reset mid-lock: while grant=4'b0010, drop reset between clock edges -> grant=0 and busy=0 immediately. After release, state is IDLE and ptr=0.
